// File: rtl/tanh_lut_loader_if.sv
// Sample stream into the tanh table loader: valid/ready handshake carrying
// one signed table entry per beat.
interface tanh_lut_loader_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/tanh_lut_loader.sv
// Run-time loader for the 17-entry piecewise-linear tanh table, with a base/next read port.
// Optional macro TANH_LUT_MONOTONIC_CHECK_EN aborts a load on a decreasing sample.
module tanh_lut_entry #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);
    always_ff @(posedge clk) begin
        if (!rst)    q <= '0;
        else if (we) q <= d;
    end
endmodule

module tanh_lut_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    tanh_lut_loader_if.slave    s,
    output logic                busy,
    output logic                table_valid,
    output logic                err,
    output logic [ADDR_W:0]     load_count,
    input  logic [ADDR_W-1:0]   rd_address,
    output logic [DATA_W-1:0]   base,
    output logic [DATA_W-1:0]   next_data
);
    localparam int DEPTH = (1 << ADDR_W) + 1;
    localparam int LCW   = ADDR_W + 1;

    typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

    state_t                        state_q;
    logic [LCW-1:0]                load_count_q;
    logic                          table_valid_q;
    logic                          ready_q;
    logic                          busy_q;
    logic [DEPTH-1:0][DATA_W-1:0]  entries;
    logic [DEPTH-1:0]              wr_en;
    logic                          accept;
    logic                          mono_fail;
    logic                          beat_ok;
    logic [LCW-1:0]                base_idx;
    logic [LCW-1:0]                next_idx;

    // start wins over a same-cycle beat: the beat is handshaken but dropped
    assign accept  = (state_q == LOAD) && s.in_valid && !start;
    assign beat_ok = accept && !mono_fail;

`ifdef TANH_LUT_MONOTONIC_CHECK_EN
    logic                 err_q;
    logic [LCW-1:0]       prev_idx;
    logic [DATA_W-1:0]    prev_entry;

    assign prev_idx   = load_count_q - 1'b1;
    assign prev_entry = (load_count_q == '0) ? '0 : entries[prev_idx];
    assign mono_fail  = accept && (load_count_q != '0) &&
                        ($signed(s.in_data) < $signed(prev_entry));
    assign err        = err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (start) err_q <= 1'b0;
        end else if (mono_fail) begin
            err_q <= 1'b1;
        end
    end
`else
    assign mono_fail = 1'b0;
    assign err       = 1'b0;
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        assign wr_en[i] = beat_ok && (load_count_q == LCW'(i));
        tanh_lut_entry #(.DATA_W(DATA_W)) u_entry (
            .clk (clk),
            .rst (rst),
            .we  (wr_en[i]),
            .d   (s.in_data),
            .q   (entries[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            load_count_q  <= '0;
            table_valid_q <= 1'b0;
            ready_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q       <= LOAD;
                        load_count_q  <= '0;
                        table_valid_q <= 1'b0;
                        ready_q       <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                LOAD: begin
                    if (start) begin
                        load_count_q <= '0;
                    end else if (mono_fail) begin
                        state_q <= IDLE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (beat_ok) begin
                        load_count_q <= load_count_q + 1'b1;
                        // table becomes visible on the same edge as the last write
                        if (load_count_q == LCW'(DEPTH - 1)) begin
                            state_q       <= IDLE;
                            table_valid_q <= 1'b1;
                            ready_q       <= 1'b0;
                            busy_q        <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s.in_ready  = ready_q;
    assign busy        = busy_q;
    assign table_valid = table_valid_q;
    assign load_count  = load_count_q;

    // index DEPTH-1 is reachable only as next_data; no wrap
    assign base_idx  = {1'b0, rd_address};
    assign next_idx  = base_idx + 1'b1;
    assign base      = table_valid_q ? entries[base_idx] : '0;
    assign next_data = table_valid_q ? entries[next_idx] : '0;
endmodule

// File: tb/tb_tanh_lut_loader.sv
// Directed self-checking bench for tanh_lut_loader: reset, ramp loads,
// backpressure, restart collision, mid-load reset and monotonic abort.
module tb_tanh_lut_loader;
    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               busy, table_valid, err;
    logic [4:0]         load_count;
    logic [3:0]         rd_address = '0;
    logic signed [7:0]  base, next_data;
    int                 checks = 0;
    int                 errors = 0;

    tanh_lut_loader_if #(.DATA_W(8)) bus ();

    tanh_lut_loader #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .s           (bus),
        .busy        (busy),
        .table_valid (table_valid),
        .err         (err),
        .load_count  (load_count),
        .rd_address  (rd_address),
        .base        (base),
        .next_data   (next_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic read_chk(input string tag, input int addr, input int eb, input int en);
        rd_address = 4'(addr);
        #1;
        chk({tag, "_base"}, base, eb);
        chk({tag, "_next"}, next_data, en);
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_ready"}, bus.in_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_tv"}, table_valid, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_cnt"}, load_count, 0);
        chk({tag, "_base"}, base, 0);
        chk({tag, "_next"}, next_data, 0);
    endtask

    // Full 17-beat load of entry k = mul*k + off, optional idle cycle before each beat.
    task automatic load17(input string tag, input int mul, input int off, input bit bp, input bit do_start);
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            chk({tag, "_ready_after_start"}, bus.in_ready, 1);
            chk({tag, "_busy_after_start"}, busy, 1);
            chk({tag, "_cnt_after_start"}, load_count, 0);
        end
        for (int k = 0; k < 17; k++) begin
            if (bp) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'h5A;
                tick();
                chk({tag, "_stall_cnt"}, load_count, k);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(mul * k + off);
            tick();
            chk({tag, "_cnt"}, load_count, k + 1);
            if (k < 16) chk({tag, "_tv_low"}, table_valid, 0);
        end
        bus.in_valid = 1'b0;
        chk({tag, "_tv_high"}, table_valid, 1);
        chk({tag, "_ready_low"}, bus.in_ready, 0);
        chk({tag, "_busy_low"}, busy, 0);
    endtask

    initial begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h33;
        start = 1'b1;
        rst   = 1'b0;
        tick();
        tick();
        idle_outputs("reset");

        rst = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        tick();
        idle_outputs("post_reset_idle");
        bus.in_valid = 1'b0;

        // Ramp -64..64 back-to-back
        load17("ramp", 8, -64, 1'b0, 1'b1);
        read_chk("ramp_a3", 3, -40, -32);
        read_chk("ramp_a15", 15, 56, 64);
        read_chk("ramp_a0", 0, -64, -56);

        // in_valid in IDLE must not write
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h11;
        tick();
        tick();
        bus.in_valid = 1'b0;
        chk("idle_valid_cnt", load_count, 17);
        read_chk("idle_valid_a0", 0, -64, -56);

        // Same ramp with backpressure
        load17("bp", 8, -64, 1'b1, 1'b1);
        read_chk("bp_a3", 3, -40, -32);
        read_chk("bp_a15", 15, 56, 64);

        // Restart with colliding beat
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rs_tv_cleared", table_valid, 0);
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(k + 1);
            tick();
        end
        chk("rs_cnt5", load_count, 5);
        start = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h7F;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b0;
        chk("rs_cnt0", load_count, 0);
        chk("rs_ready", bus.in_ready, 1);
        load17("rs_load", 3, 0, 1'b0, 1'b0);
        read_chk("rs_a0", 0, 0, 3);
        read_chk("rs_a5", 5, 15, 18);
        read_chk("rs_a15", 15, 45, 48);

        // Reset in the middle of a load
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(10 * k);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("mid_cnt9", load_count, 9);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        rd_address = 4'd0;
        #1;
        idle_outputs("mid_reset");
        tick();
        chk("mid_after_release_busy", busy, 0);

        // Decreasing fourth sample
        start = 1'b1;
        tick();
        start = 1'b0;
        begin
            int seq [4] = '{0, 10, 20, 15};
            for (int k = 0; k < 4; k++) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 8'(seq[k]);
                tick();
            end
        end
`ifdef TANH_LUT_MONOTONIC_CHECK_EN
        bus.in_valid = 1'b0;
        chk("mono_err", err, 1);
        chk("mono_tv", table_valid, 0);
        chk("mono_busy", busy, 0);
        chk("mono_ready", bus.in_ready, 0);
        chk("mono_cnt", load_count, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("mono_err_clear", err, 0);
        for (int k = 0; k < 2; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'sd5;
            tick();
        end
        bus.in_valid = 1'b0;
        chk("mono_equal_err", err, 0);
        chk("mono_equal_cnt", load_count, 2);
`else
        chk("nomono_err", err, 0);
        chk("nomono_cnt", load_count, 4);
        chk("nomono_busy", busy, 1);
        for (int k = 4; k < 17; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(k);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("nomono_tv", table_valid, 1);
        chk("nomono_err_end", err, 0);
        read_chk("nomono_a2", 2, 20, 15);
        read_chk("nomono_a15", 15, 15, 16);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
